alu_rr_arbiter: RTL and testbench
=================================

Name: alu_rr_arbiter

Overview:
- Shares one combinational add/sub datapath among NUM_REQ requesters using round-robin arbitration.
- Each requester offers an operand pair and function code over a valid/ready handshake.
- The block registers the result, signed-overflow flag and requester ID in a one-deep output stage with its own valid/ready handshake.
- Sits between execution-stage clients and the shared add/sub unit.

Parameters:
- DATA_WIDTH, 16, operand/result width in bits.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of rsp_id; must be at least clog2(NUM_REQ).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A; requester i occupies slice [i*DATA_WIDTH +: DATA_WIDTH].
- req_b  in  NUM_REQ*DATA_WIDTH  operand B, same packing as req_a.
- req_func  in  NUM_REQ*4  function code; requester i occupies slice [i*4 +: 4].
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_WIDTH  result.
- rsp_overflow  out  1  signed overflow flag.
- rsp_id  out  ID_WIDTH  index of the requester that produced the result.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - rsp_valid=0, rsp_data=0, rsp_overflow=0, rsp_id=0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while reset is asserted.
  - Reset mid-operation discards any held response with no replay.
- Output stage is free when rsp_valid=0, or when rsp_valid=1 and rsp_ready=1 in the same cycle. The drain-and-refill case gives full throughput of one operation per cycle.
- Grant (combinational):
  - When the output stage is free, grant the first requester with req_valid=1, searching ptr, ptr+1, ..., modulo NUM_REQ.
  - req_ready is asserted only for the granted index. All req_ready are 0 if the stage is not free or no request is valid.
- Handshake: a transfer occurs on a rising edge where req_valid[i]=1 and req_ready[i]=1. On that edge:
  - rsp_data and rsp_overflow are loaded from the datapath evaluated on requester i's operands.
  - rsp_id is loaded with i, and rsp_valid is set to 1.
  - ptr is loaded with (i+1) mod NUM_REQ.
- Latency: the response is visible on the cycle after the request handshake.
- Response hold: while rsp_valid=1 and rsp_ready=0, rsp_data, rsp_overflow and rsp_id are stable and no grant is issued.
- Drain without refill: when rsp_valid=1, rsp_ready=1 and no request is granted, rsp_valid clears to 0 next edge. Data fields hold their last values.
- Requesters must hold req_a, req_b and req_func stable while req_valid=1 and not yet accepted. req_valid may not drop before acceptance; the bench checks this with an assertion.
- Datapath function codes:
  - 4'b0000: C = A + B, modulo 2^DATA_WIDTH.
  - 4'b0001: C = A - B, modulo 2^DATA_WIDTH.
  - Any other code: C = 0, overflow = 0. The request is still accepted and still answered.
- Overflow, with MSB = bit DATA_WIDTH-1:
  - Add: A.msb == B.msb and C.msb != A.msb.
  - Sub: A.msb != B.msb and C.msb != A.msb.
- ptr does not advance on cycles without a handshake.
- With only one requester active, that requester is granted every free cycle regardless of ptr.

Decomposition:
- Shared package alu_pkg holds:
  - FUNC_ADD=4'b0000 and FUNC_SUB=4'b0001.
  - Default DATA_WIDTH.
  - A function computing the signed-overflow bit for add and for sub.
- One natural sub-module, rr_grant: inputs are the valid vector and ptr; outputs are a one-hot grant and the encoded index.
- The add/sub datapath is the team's existing ADD_SUB unit, instantiated once with data_width=DATA_WIDTH. Its inputs are multiplexed by the encoded grant index.

Test Plan:
- Reset: hold reset_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_data=0. Release reset -> req0 is granted first.
- Single add, overflow: req1 A=16'h7FFF, B=16'h0001, func=0000, rsp_ready=1 -> one cycle later rsp_valid=1, rsp_data=16'h8000, rsp_overflow=1, rsp_id=1.
- Sub, overflow and no-overflow:
  - req2 A=16'h8000, B=16'h0001, func=0001 -> rsp_data=16'h7FFF, rsp_overflow=1.
  - Then A=16'h0005, B=16'h0007 -> rsp_data=16'hFFFE, rsp_overflow=0.
- Round-robin fairness: all four req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles. rsp_id follows the same sequence one cycle later, with no idle cycles.
- Back-pressure: rsp_ready=0 for 5 cycles while req0 and req3 are valid -> rsp fields stable and req_ready=0 throughout. On rsp_ready=1, the next grant goes to the index after the last served requester in the same cycle.
- Illegal func and mid-reset:
  - req0 func=4'b0110, A=16'h1234 -> rsp_data=0, rsp_overflow=0, rsp_id=0.
  - Assert reset_n=0 while rsp_valid=1 -> rsp_valid drops immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the add/sub datapath and its round-robin front end.
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;

    localparam logic [3:0] FUNC_ADD = 4'b0000;
    localparam logic [3:0] FUNC_SUB = 4'b0001;

    // Two's-complement overflow from the operand and result sign bits.
    function automatic logic signedOverflow(
        input logic isSub,
        input logic aMsb,
        input logic bMsb,
        input logic cMsb
    );
        if (isSub) begin
            return (aMsb != bMsb) && (cMsb != aMsb);
        end
        return (aMsb == bMsb) && (cMsb != aMsb);
    endfunction

endpackage

// File: rtl/add_sub.sv
// Combinational add/sub unit; unknown function codes yield a zero result
// with no overflow.
module ADD_SUB
    import alu_pkg::*;
#(
    parameter int data_width = DEFAULT_DATA_WIDTH
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic [3:0]            func,
    output logic [data_width-1:0] c,
    output logic                  overflow
);

    always_comb begin
        c        = '0;
        overflow = 1'b0;
        case (func)
            FUNC_ADD: begin
                c        = a + b;
                overflow = signedOverflow(1'b0, a[data_width-1], b[data_width-1], c[data_width-1]);
            end
            FUNC_SUB: begin
                c        = a - b;
                overflow = signedOverflow(1'b1, a[data_width-1], b[data_width-1], c[data_width-1]);
            end
            default: begin
                c        = '0;
                overflow = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rr_grant.sv
// Round-robin pick: first asserted valid bit starting at ptr and wrapping
// modulo NUM_REQ. Produces a one-hot grant plus its encoded index.
module rr_grant #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grantIdx,
    output logic                 anyGrant
);

    // One extra bit so ptr + offset can be wrapped without a modulo operator.
    logic [IDX_WIDTH:0] cand;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        anyGrant = 1'b0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_WIDTH + 1)'(k);
            if (cand >= (IDX_WIDTH + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_WIDTH + 1)'(NUM_REQ);
            end
            if (!anyGrant && valid[cand[IDX_WIDTH-1:0]]) begin
                anyGrant                     = 1'b1;
                grant[cand[IDX_WIDTH-1:0]]   = 1'b1;
                grantIdx                     = cand[IDX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin sharing of one add/sub unit among NUM_REQ requesters, with a
// one-deep registered response stage.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]          req_func,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_overflow,
    output logic [ID_WIDTH-1:0]           rsp_id
);

    localparam int IDX_WIDTH = $clog2(NUM_REQ);

    logic [IDX_WIDTH-1:0]  ptr;
    logic [IDX_WIDTH-1:0]  ptrNext;
    logic [IDX_WIDTH-1:0]  grantIdx;
    logic [NUM_REQ-1:0]    grant;
    logic                  anyGrant;
    logic                  stageFree;
    logic                  handshake;
    logic [DATA_WIDTH-1:0] muxA;
    logic [DATA_WIDTH-1:0] muxB;
    logic [3:0]            muxFunc;
    logic [DATA_WIDTH-1:0] aluC;
    logic                  aluOvf;

    // Handshakes: a request transfers on a rising edge with req_valid[i] and
    // req_ready[i] both high; the response leaves on an edge with rsp_valid and
    // rsp_ready both high. The stage may refill on the same edge it drains.
    assign stageFree = !rsp_valid || rsp_ready;

    rr_grant #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) uGrant (
        .valid    (req_valid),
        .ptr      (ptr),
        .grant    (grant),
        .grantIdx (grantIdx),
        .anyGrant (anyGrant)
    );

    assign req_ready = (reset_n && stageFree) ? grant : '0;
    assign handshake = reset_n && stageFree && anyGrant;

    assign muxA    = req_a[grantIdx*DATA_WIDTH +: DATA_WIDTH];
    assign muxB    = req_b[grantIdx*DATA_WIDTH +: DATA_WIDTH];
    assign muxFunc = req_func[grantIdx*4 +: 4];

    ADD_SUB #(
        .data_width (DATA_WIDTH)
    ) uAddSub (
        .a        (muxA),
        .b        (muxB),
        .func     (muxFunc),
        .c        (aluC),
        .overflow (aluOvf)
    );

    assign ptrNext = (grantIdx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            rsp_id       <= '0;
            ptr          <= '0;
        end else if (handshake) begin
            rsp_valid    <= 1'b1;
            rsp_data     <= aluC;
            rsp_overflow <= aluOvf;
            rsp_id       <= ID_WIDTH'(grantIdx);
            ptr          <= ptrNext;
        end else if (rsp_ready) begin
            // Drain without refill: data fields keep their last values.
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a queue-based behavioural model.
module tb_alu_rr_arbiter;

    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int EW = IW + 1 + DW;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*DW-1:0] req_a;
    logic [NR*DW-1:0] req_b;
    logic [NR*4-1:0] req_func;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_data;
    logic            rsp_overflow;
    logic [IW-1:0]   rsp_id;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected response register contents, packed {id, overflow, data}.
    logic [EW-1:0] exp_q[$];
    int            m_ptr;

    alu_rr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_WIDTH   (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_func     (req_func),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_overflow (rsp_overflow),
        .rsp_id       (rsp_id)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result from signed integer arithmetic: overflow means the exact signed
    // answer does not fit in DW bits.
    function automatic logic [EW-1:0] model_rsp(input int id, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b, input logic [3:0] f);
        int            sa;
        int            sb;
        int            r;
        logic          ovf;
        logic [DW-1:0] d;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (f == 4'd0)      r = sa + sb;
        else if (f == 4'd1) r = sa - sb;
        else                r = 0;
        ovf = (r > 32767) || (r < -32768);
        d   = r[DW-1:0];
        return {IW'(id), ovf, d};
    endfunction

    // ---------------- scoreboard / compare process ----------------
    logic [NR-1:0]    prev_pend;
    logic [NR*DW-1:0] prev_a;
    logic [NR*DW-1:0] prev_b;
    logic [NR*4-1:0]  prev_f;
    logic             prev_ok = 1'b0;

    always @(negedge clk) begin : model
        int            g;
        int            idx;
        bit            free;
        logic [NR-1:0] exp_rdy;
        logic [EW-1:0] head;
        if (!reset_n) begin
            exp_q.delete();
            m_ptr   = 0;
            prev_ok = 1'b0;
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_data", 32'(rsp_data), 32'd0);
            check("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
            check("rst_rsp_id", 32'(rsp_id), 32'd0);
        end else begin
            if (prev_ok) begin
                for (int i = 0; i < NR; i++) begin
                    if (prev_pend[i]) begin
                        assert (req_valid[i] && req_a[i*DW +: DW] == prev_a[i*DW +: DW] &&
                                req_b[i*DW +: DW] == prev_b[i*DW +: DW] &&
                                req_func[i*4 +: 4] == prev_f[i*4 +: 4])
                        else $error("requester %0d dropped or changed before acceptance", i);
                    end
                end
            end
            check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                head = exp_q[0];
                check("rsp_data", 32'(rsp_data), 32'(head[DW-1:0]));
                check("rsp_overflow", 32'(rsp_overflow), 32'(head[DW]));
                check("rsp_id", 32'(rsp_id), 32'(head[EW-1:DW+1]));
            end
            free = (exp_q.size() == 0) || rsp_ready;
            g    = -1;
            if (free) begin
                for (int k = 0; k < NR; k++) begin
                    idx = (m_ptr + k) % NR;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_q.size() != 0 && rsp_ready) void'(exp_q.pop_front());
            if (g >= 0) begin
                exp_q.push_back(model_rsp(g, req_a[g*DW +: DW], req_b[g*DW +: DW], req_func[g*4 +: 4]));
                m_ptr = (g + 1) % NR;
            end
            prev_pend = req_valid & ~req_ready;
            prev_a    = req_a;
            prev_b    = req_b;
            prev_f    = req_func;
            prev_ok   = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [3:0] f);
        req_a[i*DW +: DW] = a;
        req_b[i*DW +: DW] = b;
        req_func[i*4 +: 4] = f;
    endtask

    // Retire every pending request, dropping each valid only once accepted.
    task automatic drain();
        logic [NR-1:0] g;
        rsp_ready = 1'b1;
        for (int n = 0; n < 64 && req_valid != '0; n++) begin
            @(negedge clk);
            g = req_ready;
            tick();
            req_valid = req_valid & ~g;
        end
        check("drain_done", 32'(req_valid), 32'd0);
    endtask

    // Issue one request on requester i and check the registered response.
    // Returns at a falling edge with the response visible.
    task automatic do_single(input string name, input int i, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [3:0] f, input bit hold,
                             input logic [DW-1:0] exp_d, input logic exp_o);
        bit ok;
        ok = 1'b0;
        set_req(i, a, b, f);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_granted"}, 32'(ok), 32'd1);
        tick();
        req_valid[i] = 1'b0;
        if (hold) rsp_ready = 1'b0;
        @(negedge clk);
        check({name, "_valid"}, 32'(rsp_valid), 32'd1);
        check({name, "_data"}, 32'(rsp_data), 32'(exp_d));
        check({name, "_ovf"}, 32'(rsp_overflow), 32'(exp_o));
        check({name, "_id"}, 32'(rsp_id), 32'(i));
    endtask

    function automatic logic [DW-1:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            3:       return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rand_func();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return 4'b0000;
        if (r < 8) return 4'b0001;
        return 4'($urandom_range(2, 15));
    endfunction

    // ---------------- main sequence ----------------
    initial begin : main
        int            fair_id[7];
        logic [NR-1:0] acc;
        fair_id = '{0, 1, 2, 3, 0, 1, 2};

        reset_n   = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < NR; i++) set_req(i, DW'(16'h0100 * (i + 1)), DW'(i), 4'b0000);

        repeat (2) begin
            @(negedge clk);
            check("hold_rst_req_ready", 32'(req_ready), 32'd0);
            check("hold_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        tick();
        reset_n = 1'b1;

        // Fairness: all requesters stay valid; grants rotate with no idle cycle.
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("fair_grant", 32'(req_ready), 32'(1 << fair_id[k]));
            if (k > 0) begin
                check("fair_rsp_valid", 32'(rsp_valid), 32'd1);
                check("fair_rsp_id", 32'(rsp_id), 32'(fair_id[k-1]));
            end
            tick();
        end
        drain();

        do_single("add_ovf", 1, 16'h7FFF, 16'h0001, 4'b0000, 1'b0, 16'h8000, 1'b1);
        tick();
        do_single("sub_ovf", 2, 16'h8000, 16'h0001, 4'b0001, 1'b0, 16'h7FFF, 1'b1);
        tick();
        do_single("sub_neg", 2, 16'h0005, 16'h0007, 4'b0001, 1'b0, 16'hFFFE, 1'b0);
        tick();

        // Back-pressure: response from requester 2 held while 0 and 3 wait.
        rsp_ready = 1'b1;
        do_single("bp_load", 2, 16'h0010, 16'h0020, 4'b0000, 1'b1, 16'h0030, 1'b0);
        tick();
        set_req(0, 16'h1111, 16'h0001, 4'b0000);
        set_req(3, 16'h3333, 16'h0003, 4'b0001);
        req_valid = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'h0030);
            check("bp_rsp_id", 32'(rsp_id), 32'd2);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", 32'(req_ready), 32'b1000);
        tick();
        @(negedge clk);
        check("bp_next_grant", 32'(req_ready), 32'b0001);
        check("bp_next_id", 32'(rsp_id), 32'd3);
        check("bp_next_data", 32'(rsp_data), 32'h3330);
        tick();
        req_valid[0] = 1'b0;
        drain();

        // Illegal function code, then asynchronous reset with a held response.
        do_single("illegal", 0, 16'h1234, 16'h5678, 4'b0110, 1'b1, 16'h0000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        tick();
        reset_n   = 1'b1;
        rsp_ready = 1'b1;

        // Randomized traffic with protocol-respecting requesters.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            tick();
            rsp_ready = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 3) != 0);
                    set_req(i, rand_operand(), rand_operand(), rand_func());
                end
            end
        end
        drain();
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
